// File: rtl/mem_responder_if.sv
// Instruction-fetch and data request/response bundle between a core and mem_responder.
interface mem_responder_if #(
  parameter int LEN_WORD = 32
);
  logic                i_req;
  logic [31:0]         i_addr;
  logic [LEN_WORD-1:0] i_data;
  logic                i_ack;
  logic                d_req;
  logic                d_we;
  logic [31:0]         d_addr;
  logic [LEN_WORD-1:0] d_wdata;
  logic [LEN_WORD-1:0] d_rdata;
  logic                d_ack;
  logic                err;
  logic                proto_err;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_data, i_ack, d_rdata, d_ack, err, proto_err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_data, i_ack, d_rdata, d_ack, err, proto_err
  );
endinterface

// File: rtl/mem_responder.sv
// Two-port (fetch + data) responder sharing one single-port word array;
// data wins collisions, each access runs IDLE -> ACCESS -> RESP.
module mem_responder #(
  parameter int LEN_WORD = 32,
  parameter int ADDR_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic                i_pend, d_pend;
  logic [ADDR_W+1:0]   i_addr_q, d_addr_q;
  logic                d_we_q;
  logic [LEN_WORD-1:0] d_wdata_q;

  logic                srv_d;
  logic [ADDR_W+1:0]   srv_addr;
  logic                srv_we;
  logic [LEN_WORD-1:0] srv_wdata;

  logic [LEN_WORD-1:0] mem [2**ADDR_W];

  logic                i_take, d_take, i_viol, d_viol;
  logic                d_any, i_any;
  logic [ADDR_W+1:0]   d_sel_addr, i_sel_addr;
  logic                d_sel_we;
  logic [LEN_WORD-1:0] d_sel_wdata;
  logic [ADDR_W-1:0]   idx;
  logic                fault;
  logic                mem_we;

  // Upper address bits are deliberately dropped so addresses wrap around the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.i_addr[31:ADDR_W+2], bus.d_addr[31:ADDR_W+2]};

  // A port's pending bit covers both waiting and in-flight, so a repeat pulse is a violation.
  assign i_take = bus.i_req && !i_pend;
  assign d_take = bus.d_req && !d_pend;
  assign i_viol = bus.i_req && i_pend;
  assign d_viol = bus.d_req && d_pend;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    d_any       = d_pend || d_take;
    i_any       = i_pend || i_take;
    d_sel_addr  = bus.d_addr[ADDR_W+1:0];
    d_sel_we    = bus.d_we;
    d_sel_wdata = bus.d_wdata;
    i_sel_addr  = bus.i_addr[ADDR_W+1:0];
    if (d_pend) begin
      d_sel_addr  = d_addr_q;
      d_sel_we    = d_we_q;
      d_sel_wdata = d_wdata_q;
    end
    if (i_pend) i_sel_addr = i_addr_q;
  end

  assign idx    = srv_addr[ADDR_W+1:2];
  assign fault  = (srv_addr[1:0] != 2'b00);
  assign mem_we = (state == ACCESS) && srv_we && !fault;

  // NOTE: the array has no reset; its contents must survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= srv_wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments to avoid simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      i_pend        <= 1'b0;
      d_pend        <= 1'b0;
      i_addr_q      <= '0;
      d_addr_q      <= '0;
      d_we_q        <= 1'b0;
      d_wdata_q     <= '0;
      srv_d         <= 1'b0;
      srv_addr      <= '0;
      srv_we        <= 1'b0;
      srv_wdata     <= '0;
      bus.i_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.err       <= 1'b0;
      bus.proto_err <= 1'b0;
      bus.i_data    <= '0;
      bus.d_rdata   <= '0;
    end else begin
      if (i_take) begin
        i_pend   <= 1'b1;
        i_addr_q <= bus.i_addr[ADDR_W+1:0];
      end
      if (d_take) begin
        d_pend    <= 1'b1;
        d_addr_q  <= bus.d_addr[ADDR_W+1:0];
        d_we_q    <= bus.d_we;
        d_wdata_q <= bus.d_wdata;
      end
      if (i_viol || d_viol) bus.proto_err <= 1'b1;

      case (state)
        IDLE: begin
          if (d_any) begin
            srv_d     <= 1'b1;
            srv_addr  <= d_sel_addr;
            srv_we    <= d_sel_we;
            srv_wdata <= d_sel_wdata;
            state     <= ACCESS;
          end else if (i_any) begin
            srv_d    <= 1'b0;
            srv_addr <= i_sel_addr;
            srv_we   <= 1'b0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          bus.err <= fault;
          if (srv_d) begin
            bus.d_ack <= 1'b1;
            if (!srv_we) bus.d_rdata <= fault ? '0 : mem[idx];
          end else begin
            bus.i_ack  <= 1'b1;
            bus.i_data <= fault ? '0 : mem[idx];
          end
          state <= RESP;
        end
        RESP: begin
          bus.i_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          bus.err   <= 1'b0;
          if (srv_d) d_pend <= 1'b0;
          else       i_pend <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected acks (cycle, err, data) are queued at drive time.
module tb_mem_responder;
  localparam int LW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if #(.LEN_WORD(LW)) bus ();
  mem_responder #(.LEN_WORD(LW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int           cyc;
    bit           err;
    logic [LW-1:0] data;
  } exp_t;

  exp_t          d_q[$];
  exp_t          i_q[$];
  logic [LW-1:0] model [int];
  logic [LW-1:0] d_rdata_m = '0;
  logic [LW-1:0] i_data_m  = '0;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int widx(logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  // Response monitor: pops the scoreboard on each ack and checks timing and payload.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checks++;
      if ((bus.i_ack && bus.d_ack) !== 1'b0) begin
        errors++;
        $display("FAIL ack_overlap: i_ack=%b d_ack=%b at cycle %0d", bus.i_ack, bus.d_ack, cyc);
      end
      if (!bus.i_ack && !bus.d_ack) begin
        checks++;
        if (bus.err !== 1'b0) begin
          errors++;
          $display("FAIL err_idle: err=%b required 0 at cycle %0d", bus.err, cyc);
        end
      end
      if (bus.d_ack) begin
        checks++;
        if (d_q.size() == 0) begin
          errors++;
          $display("FAIL d_ack_unexpected: d_ack at cycle %0d with nothing outstanding", cyc);
        end else begin
          e = d_q.pop_front();
          if (cyc !== e.cyc || bus.err !== e.err || bus.d_rdata !== e.data) begin
            errors++;
            $display("FAIL d_resp: cycle %0d err %b d_rdata %h, required cycle %0d err %b d_rdata %h",
                     cyc, bus.err, bus.d_rdata, e.cyc, e.err, e.data);
          end
        end
      end
      if (bus.i_ack) begin
        checks++;
        if (i_q.size() == 0) begin
          errors++;
          $display("FAIL i_ack_unexpected: i_ack at cycle %0d with nothing outstanding", cyc);
        end else begin
          e = i_q.pop_front();
          if (cyc !== e.cyc || bus.err !== e.err || bus.i_data !== e.data) begin
            errors++;
            $display("FAIL i_resp: cycle %0d err %b i_data %h, required cycle %0d err %b i_data %h",
                     cyc, bus.err, bus.i_data, e.cyc, e.err, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  task automatic drive_d(bit we, logic [31:0] a, logic [LW-1:0] wd, int lat);
    exp_t e;
    bit   f;
    f = (a[1:0] != 2'b00);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    e.cyc = cyc + lat;
    e.err = f;
    if (we) begin
      if (!f) model[widx(a)] = wd;
    end else begin
      d_rdata_m = f ? '0 : model[widx(a)];
    end
    e.data = d_rdata_m;
    d_q.push_back(e);
  endtask

  task automatic drive_i(logic [31:0] a, int lat);
    exp_t e;
    bit   f;
    f = (a[1:0] != 2'b00);
    bus.i_req = 1'b1; bus.i_addr = a;
    i_data_m = f ? '0 : model[widx(a)];
    e.cyc  = cyc + lat;
    e.err  = f;
    e.data = i_data_m;
    i_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && (d_q.size() != 0 || i_q.size() != 0); k++) tick();
    checks++;
    if (d_q.size() != 0 || i_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d data and %0d fetch responses still outstanding, required 0",
               d_q.size(), i_q.size());
      d_q.delete();
      i_q.delete();
    end
  endtask

  task automatic check_outputs_zero(string tag);
    checks++;
    if ({bus.i_ack, bus.d_ack, bus.err, bus.proto_err} !== 4'b0 ||
        bus.i_data !== '0 || bus.d_rdata !== '0) begin
      errors++;
      $display("FAIL %s: i_ack=%b d_ack=%b err=%b proto_err=%b i_data=%h d_rdata=%h, required all 0",
               tag, bus.i_ack, bus.d_ack, bus.err, bus.proto_err, bus.i_data, bus.d_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.i_addr = '0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) tick();
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    tick();
    check_outputs_zero("post_reset_outputs");
  endtask

  task automatic test_store_load();
    drive_d(1'b1, 32'h10, 32'hDEADBEEF, 2); tick(); idle_inputs(); wait_drain();
    drive_d(1'b0, 32'h10, '0, 2);           tick(); idle_inputs(); wait_drain();
    drive_d(1'b1, 32'h20, 32'hCAFEF00D, 2); tick(); idle_inputs(); wait_drain();
    drive_i(32'h20, 2);                     tick(); idle_inputs(); wait_drain();
  endtask

  task automatic test_collision();
    drive_d(1'b1, 32'h10, 32'h12345678, 2);
    drive_i(32'h10, 5);
    tick(); idle_inputs(); wait_drain();
  endtask

  task automatic test_back_to_back();
    // Fetch arrives during ACCESS, then during RESP, of a data load.
    drive_d(1'b0, 32'h10, '0, 2); tick(); idle_inputs();
    drive_i(32'h20, 4);            tick(); idle_inputs(); wait_drain();
    drive_d(1'b0, 32'h20, '0, 2); tick(); idle_inputs(); tick();
    drive_i(32'h10, 3);            tick(); idle_inputs(); wait_drain();
  endtask

  task automatic test_misaligned();
    drive_d(1'b0, 32'h13, '0, 2);           tick(); idle_inputs(); wait_drain();
    drive_d(1'b1, 32'h22, 32'h55555555, 2); tick(); idle_inputs(); wait_drain();
    drive_d(1'b0, 32'h20, '0, 2);           tick(); idle_inputs(); wait_drain();
    drive_i(32'h11, 2);                     tick(); idle_inputs(); wait_drain();
  endtask

  task automatic test_wrap();
    drive_d(1'b1, 32'h4000, 32'h1, 2); tick(); idle_inputs(); wait_drain();
    drive_d(1'b0, 32'h0, '0, 2);       tick(); idle_inputs(); wait_drain();
  endtask

  task automatic test_protocol();
    checks++;
    if (bus.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_before: proto_err=%b required 0", bus.proto_err);
    end
    drive_i(32'h10, 2); tick();
    bus.i_addr = 32'h20;
    checks++;
    if (bus.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_cycle1: proto_err=%b required 0", bus.proto_err);
    end
    tick(); idle_inputs();
    checks++;
    if (bus.proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_cycle2: proto_err=%b required 1", bus.proto_err);
    end
    wait_drain();
    repeat (3) tick();
    checks++;
    if (bus.proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky: proto_err=%b required 1", bus.proto_err);
    end
  endtask

  task automatic test_reset_mid_access();
    drive_d(1'b1, 32'h40, 32'h11111111, 2); tick(); idle_inputs(); wait_drain();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hA5A5A5A5;
    tick(); idle_inputs();
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid_access");
    d_rdata_m = '0;
    i_data_m  = '0;
    #1 rst = 1'b0;
    repeat (5) tick();
    check_outputs_zero("after_abort");
    drive_d(1'b0, 32'h40, '0, 2); tick(); idle_inputs(); wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_collision();
    test_back_to_back();
    test_misaligned();
    test_wrap();
    test_protocol();
    test_reset_mid_access();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
